// File: rtl/i2c_frame_decoder.sv
// Passive I2C frame decoder: synchronises SCL/SDA, detects START/STOP/repeated START,
// assembles bytes plus ACK bit and flags frames aborted mid-byte.
module i2c_frame_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       start_det,
    output logic       stop_det,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_first,
    output logic       ack_bit,
    output logic       bus_busy,
    output logic       frame_err
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_cur;
    logic                   sda_cur;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;

    logic scl_rise;
    logic scl_fall;
    logic ev_start;
    logic ev_stop;
    logic abort_err;

    state_t     state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shift, shift_nx;
    logic       first, first_nx;
    logic       bit_open, bit_open_nx;
    logic       start_nx, stop_nx, valid_nx, err_nx, busy_nx;
    logic [7:0] data_nx;
    logic       bfirst_nx, ack_nx;

    // Input synchroniser, previous-sample flops and arm counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            arm_cnt  <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
            if (!armed)
                arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign scl_cur = scl_sync[SYNC_STAGES-1];
    assign sda_cur = sda_sync[SYNC_STAGES-1];
    assign armed   = (arm_cnt == ARM_W'(ARM_CYCLES));

    // START/STOP need SCL high in both samples, so a simultaneous SCL+SDA change never counts
    assign scl_rise = armed & ~scl_prev & scl_cur;
    assign scl_fall = armed & scl_prev & ~scl_cur;
    assign ev_start = armed & scl_prev & scl_cur & sda_prev & ~sda_cur;
    assign ev_stop  = armed & scl_prev & scl_cur & ~sda_prev & sda_cur;

    // The SCL rise that opens a START/STOP high phase has already been shifted in as a bit;
    // bit_open marks it so it is not counted as a real data bit when judging an abort.
    assign abort_err = (state == ACK) ||
                       ((state == DATA) && (bit_cnt != {2'b00, bit_open}));

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        shift_nx    = shift;
        first_nx    = first;
        bit_open_nx = bit_open;
        start_nx    = 1'b0;
        stop_nx     = 1'b0;
        valid_nx    = 1'b0;
        err_nx      = 1'b0;
        busy_nx     = bus_busy;
        data_nx     = byte_data;
        bfirst_nx   = byte_first;
        ack_nx      = ack_bit;

        if (ev_stop && state != IDLE) begin
            err_nx      = abort_err;
            stop_nx     = 1'b1;
            busy_nx     = 1'b0;
            state_nx    = IDLE;
            bit_cnt_nx  = 3'd0;
            first_nx    = 1'b0;
            bit_open_nx = 1'b0;
        end else if (ev_start) begin
            err_nx      = abort_err;
            start_nx    = 1'b1;
            busy_nx     = 1'b1;
            state_nx    = DATA;
            bit_cnt_nx  = 3'd0;
            first_nx    = 1'b1;
            bit_open_nx = 1'b0;
        end else begin
            if (scl_fall)
                bit_open_nx = 1'b0;
            if (scl_rise) begin
                case (state)
                    DATA: begin
                        shift_nx    = {shift[6:0], sda_cur};
                        bit_cnt_nx  = bit_cnt + 3'd1;
                        bit_open_nx = 1'b1;
                        if (bit_cnt == 3'd7)
                            state_nx = ACK;
                    end
                    ACK: begin
                        ack_nx      = sda_cur;
                        data_nx     = shift;
                        bfirst_nx   = first;
                        valid_nx    = 1'b1;
                        first_nx    = 1'b0;
                        bit_open_nx = 1'b0;
                        state_nx    = DATA;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Decoder state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            first      <= 1'b0;
            bit_open   <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            bus_busy   <= 1'b0;
            byte_data  <= 8'h00;
            byte_first <= 1'b0;
            ack_bit    <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shift      <= shift_nx;
            first      <= first_nx;
            bit_open   <= bit_open_nx;
            start_det  <= start_nx;
            stop_det   <= stop_nx;
            byte_valid <= valid_nx;
            frame_err  <= err_nx;
            bus_busy   <= busy_nx;
            byte_data  <= data_nx;
            byte_first <= bfirst_nx;
            ack_bit    <= ack_nx;
        end
    end

endmodule

// File: tb/tb_i2c_frame_decoder.sv
// Directed bench for i2c_frame_decoder: table-driven byte frames plus hand-written
// reset, latency, abort, repeated START and idle-noise sequences.
module tb_i2c_frame_decoder;

    logic       clk;
    logic       reset_n;
    logic       scl_in;
    logic       sda_in;
    logic       start_det;
    logic       stop_det;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_first;
    logic       ack_bit;
    logic       bus_busy;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    int n_start = 0;
    int n_stop  = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_excl  = 0;
    int n_err_alone = 0;
    int n_busy_bad  = 0;

    int s_start, s_stop, s_valid, s_err;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       exp_first;
    } vec_t;

    vec_t vecs[3];

    i2c_frame_decoder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_first (byte_first),
        .ack_bit    (ack_bit),
        .bus_busy   (bus_busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            n_start <= n_start + int'(start_det);
            n_stop  <= n_stop + int'(stop_det);
            n_valid <= n_valid + int'(byte_valid);
            n_err   <= n_err + int'(frame_err);
            if (int'(start_det) + int'(stop_det) + int'(byte_valid) > 1)
                n_excl <= n_excl + 1;
            if (frame_err && !(start_det || stop_det))
                n_err_alone <= n_err_alone + 1;
            if ((start_det && !bus_busy) || (stop_det && bus_busy))
                n_busy_bad <= n_busy_bad + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic bus_set(input logic scl, input logic sda, input int n);
        scl_in = scl;
        sda_in = sda;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        @(negedge clk);
        s_start = n_start;
        s_stop  = n_stop;
        s_valid = n_valid;
        s_err   = n_err;
    endtask

    task automatic i2c_start();
        bus_set(1'b1, 1'b1, 4);
        bus_set(1'b1, 1'b0, 4);
        bus_set(1'b0, 1'b0, 4);
    endtask

    task automatic i2c_rep_start();
        bus_set(1'b0, 1'b1, 4);
        bus_set(1'b1, 1'b1, 4);
        bus_set(1'b1, 1'b0, 4);
        bus_set(1'b0, 1'b0, 4);
    endtask

    task automatic i2c_stop();
        bus_set(1'b0, 1'b0, 4);
        bus_set(1'b1, 1'b0, 4);
        bus_set(1'b1, 1'b1, 8);
    endtask

    task automatic send_bit(input logic b);
        bus_set(1'b0, b, 4);
        bus_set(1'b1, b, 4);
        bus_set(1'b0, b, 4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--)
            send_bit(b[i]);
        send_bit(ack);
    endtask

    initial begin
        vecs[0] = '{data: 8'h78, ack: 1'b0, exp_first: 1'b1};
        vecs[1] = '{data: 8'h00, ack: 1'b0, exp_first: 1'b0};
        vecs[2] = '{data: 8'hAF, ack: 1'b1, exp_first: 1'b0};

        // Reset with random bus activity, then release with SDA held low
        reset_n = 1'b0;
        scl_in  = 1'b1;
        sda_in  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            scl_in = 1'($urandom_range(0, 1));
            sda_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_outputs_zero",
                  int'({start_det, stop_det, byte_valid, byte_data, byte_first,
                        ack_bit, bus_busy, frame_err}), 0);
        end
        scl_in = 1'b1;
        sda_in = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("no_start_after_release", n_start, 0);
        check("idle_after_release_busy", int'(bus_busy), 0);
        bus_set(1'b1, 1'b1, 10);
        check("no_stop_in_idle", n_stop, 0);

        // Single byte 0x78 + ACK with START latency check
        snap();
        @(posedge clk);
        #2;
        sda_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("start_latency_early", int'(start_det), 0);
        @(negedge clk);
        check("start_latency_on_time", int'(start_det), 1);
        @(negedge clk);
        check("start_one_cycle", int'(start_det), 0);
        check("busy_after_start", int'(bus_busy), 1);
        bus_set(1'b1, 1'b0, 2);
        bus_set(1'b0, 1'b0, 4);
        send_byte(8'h78, 1'b0);
        check("single_valid_count", n_valid - s_valid, 1);
        check("single_data", int'(byte_data), 8'h78);
        check("single_first", int'(byte_first), 1);
        check("single_ack", int'(ack_bit), 0);
        check("single_busy_before_stop", int'(bus_busy), 1);
        i2c_stop();
        check("single_stop_count", n_stop - s_stop, 1);
        check("single_start_count", n_start - s_start, 1);
        check("single_no_err", n_err - s_err, 0);
        check("single_busy_after_stop", int'(bus_busy), 0);

        // Three-byte frame from the vector table
        snap();
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(vecs[i].data, vecs[i].ack);
            check($sformatf("tbl%0d_valid_count", i), n_valid - s_valid, i + 1);
            check($sformatf("tbl%0d_data", i), int'(byte_data), int'(vecs[i].data));
            check($sformatf("tbl%0d_first", i), int'(byte_first), int'(vecs[i].exp_first));
            check($sformatf("tbl%0d_ack", i), int'(ack_bit), int'(vecs[i].ack));
        end
        i2c_stop();
        check("tbl_no_err", n_err - s_err, 0);
        check("tbl_stop_count", n_stop - s_stop, 1);

        // Abort after three data bits
        snap();
        i2c_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_stop();
        check("abort_err_count", n_err - s_err, 1);
        check("abort_stop_count", n_stop - s_stop, 1);
        check("abort_no_valid", n_valid - s_valid, 0);
        check("abort_busy", int'(bus_busy), 0);

        // Repeated START between two complete bytes
        snap();
        i2c_start();
        send_byte(8'h78, 1'b0);
        i2c_rep_start();
        check("rs_busy_after_rs", int'(bus_busy), 1);
        send_byte(8'h79, 1'b0);
        check("rs_start_count", n_start - s_start, 2);
        check("rs_no_err", n_err - s_err, 0);
        check("rs_no_stop", n_stop - s_stop, 0);
        check("rs_valid_count", n_valid - s_valid, 2);
        check("rs_data", int'(byte_data), 8'h79);
        check("rs_first", int'(byte_first), 1);
        check("rs_busy_before_stop", int'(bus_busy), 1);
        i2c_stop();

        // SCL noise in IDLE, then simultaneous SCL/SDA switches
        snap();
        for (int i = 0; i < 9; i++) begin
            bus_set(1'b0, 1'b1, 4);
            bus_set(1'b1, 1'b1, 4);
        end
        bus_set(1'b0, 1'b0, 6);
        bus_set(1'b1, 1'b1, 6);
        bus_set(1'b1, 1'b1, 4);
        check("idle_no_valid", n_valid - s_valid, 0);
        check("idle_no_start", n_start - s_start, 0);
        check("idle_no_stop", n_stop - s_stop, 0);
        check("idle_busy", int'(bus_busy), 0);

        check("pulses_exclusive", n_excl, 0);
        check("err_only_with_event", n_err_alone, 0);
        check("busy_tracks_start_stop", n_busy_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
